// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and stalls on the shared memory's ready handshake.
module mips_multicycle_ctrl #(
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter logic [5:0]  JR_FUNCT    = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       bytesel,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12
    } state_t;

    state_t     state_r;
    state_t     next_s;
    logic       ready_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       regwrite_s;
    logic       bytesel_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] aluop_s;
    logic [1:0] pcsrc_s;
    logic       illegal_s;

    assign ready_s = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        next_s     = state_r;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        iord_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        bytesel_s  = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        aluop_s    = 2'b00;
        pcsrc_s    = 2'b00;
        illegal_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb_s = 2'b01;
                irwrite_s = ready_s;
                pcwrite_s = ready_s;
                if (ready_s) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
                case (op)
                    OP_LW, OP_LBU, OP_SW: next_s = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == JR_FUNCT) begin
                            next_s = S_JR;
                        end else begin
                            next_s = S_EXEC;
                        end
                    end
                    OP_BEQ:  next_s = S_BRANCH;
                    OP_ADDI: next_s = S_ADDIEX;
                    OP_J:    next_s = S_JUMP;
                    default: begin
                        next_s    = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (op == OP_SW) begin
                    next_s = S_MEMWR;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                iord_s = 1'b1;
                if (ready_s) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                bytesel_s  = (op == OP_LBU);
                next_s     = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe stays up until memory accepts the write.
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                if (ready_s) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b10;
                next_s    = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                next_s     = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b01;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
                next_s    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                next_s    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                next_s     = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
                next_s    = S_FETCH;
            end
            S_JR: begin
                pcsrc_s   = 2'b11;
                pcwrite_s = 1'b1;
                next_s    = S_FETCH;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is held, even though FETCH would raise them.
    assign irwrite  = irwrite_s & reset;
    assign pcen     = (pcwrite_s | (branch_s & zero)) & reset;
    assign regwrite = regwrite_s & reset;
    assign memwrite = memwrite_s & reset;
    assign illegal  = illegal_s & reset;
    assign iord     = iord_s;
    assign regdst   = regdst_s;
    assign memtoreg = memtoreg_s;
    assign bytesel  = bytesel_s;
    assign alusrca  = alusrca_s;
    assign alusrcb  = alusrcb_s;
    assign aluop    = aluop_s;
    assign pcsrc    = pcsrc_s;
    assign state    = state_r;

endmodule
